link_arbiter: RTL and testbench

- Sequences the master-to-slave byte link and shares it between N_REQ requesters.
- Each requester asks for one fixed-length burst; the block grants round-robin, drives the byte-level four-phase req/ack handshake, counts bytes and pulses a per-requester done.
- Sits between the requesting blocks and the link slave inside link_top. The link datapath then has a single driver.

---
 rtl/link_arbiter_pkg.sv | 16 +
 rtl/link_arbiter_rr_picker.sv | 29 ++
 rtl/link_arbiter.sv | 156 +++++++++++++++
 tb/tb_link_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/link_arbiter_pkg.sv
// Shared types and defaults for the link arbiter.
// State encodings and default link geometry.
package link_arbiter_pkg;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_BURST_LEN = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DROP = 2'd2,
    FIN  = 2'd3
  } state_e;

endpackage

// File: rtl/link_arbiter_rr_picker.sv
// rr_picker: combinational round-robin select.
// req_i/ptr_i in; one-hot win_o and valid_o out.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] win_o,
  output logic             valid_o
);

  logic [PTR_W-1:0] idx;

  // Scan ptr, ptr+1, ... and keep the first hit.
  always_comb begin
    win_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = PTR_W'((int'(ptr_i) + off) % N_REQ);
      if (!valid_o && req_i[idx]) begin
        win_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/link_arbiter.sv
// link_arbiter: round-robin burst grant + 4-phase byte link master.
// Ports: clk, rst(async low), req, burst_data, gnt, done, busy, link_*.
module link_arbiter
  import link_arbiter_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_REQ-1:0]                req,
  input  logic [N_REQ*BURST_LEN*DATA_W-1:0] burst_data,
  output logic [N_REQ-1:0]                gnt,
  output logic [N_REQ-1:0]                done,
  output logic                            busy,
  output logic                            link_req,
  output logic [DATA_W-1:0]               link_data,
  input  logic                            link_ack
);

  localparam int CNT_W =
    (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int PTR_W =
    (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [CNT_W-1:0] LAST_B =
    CNT_W'(BURST_LEN - 1);
  localparam logic [PTR_W-1:0] LAST_R =
    PTR_W'(N_REQ - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    win_q, win_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    done_q, done_d;
  logic                busy_q, busy_d;
  logic                lreq_q, lreq_d;
  logic [DATA_W-1:0]   ldat_q, ldat_d;

  logic [N_REQ-1:0]    pick_oh;
  logic                pick_vld;
  logic [PTR_W-1:0]    pick_idx;
  logic [CNT_W-1:0]    cnt_nx;

  function automatic logic [DATA_W-1:0] byte_at(
    input logic [N_REQ*BURST_LEN*DATA_W-1:0] d,
    input logic [PTR_W-1:0]                  r,
    input logic [CNT_W-1:0]                  k
  );
    return d[(int'(r)*BURST_LEN + int'(k))*DATA_W +: DATA_W];
  endfunction

  rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .win_o   (pick_oh),
    .valid_o (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_oh[i]) pick_idx = PTR_W'(i);
    end
  end

  assign cnt_nx = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    busy_d  = busy_q;
    lreq_d  = lreq_q;
    ldat_d  = ldat_q;
    unique case (state_q)
      IDLE: begin
        // A stale ack from before reset must fall first.
        if (pick_vld && !link_ack) begin
          gnt_d   = pick_oh;
          win_d   = pick_idx;
          busy_d  = 1'b1;
          cnt_d   = '0;
          ldat_d  = byte_at(burst_data, pick_idx, '0);
          lreq_d  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (link_ack) begin
          lreq_d  = 1'b0;
          state_d = DROP;
        end
      end
      DROP: begin
        if (!link_ack) begin
          if (cnt_q == LAST_B) begin
            done_d  = gnt_q;
            state_d = FIN;
          end else begin
            cnt_d   = cnt_nx;
            ldat_d  = byte_at(burst_data, win_q, cnt_nx);
            lreq_d  = 1'b1;
            state_d = SEND;
          end
        end
      end
      FIN: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        ptr_d   = (win_q == LAST_R) ? '0
                                    : win_q + PTR_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      lreq_q  <= 1'b0;
      ldat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      lreq_q  <= lreq_d;
      ldat_q  <= ldat_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign link_req  = lreq_q;
  assign link_data = ldat_q;

endmodule

// File: tb/tb_link_arbiter.sv
// tb_link_arbiter: directed bench for link_arbiter.
// Slave model with programmable ack/release delay.
module tb_link_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [127:0] burst_data;
  logic [3:0]  gnt, done;
  logic        busy, link_req;
  logic [7:0]  link_data;
  logic        link_ack;

  logic        slave_en = 1'b1;
  logic        ack_tb = 1'b0;
  logic        ack_slv = 1'b0;
  int          ack_dly = 1;
  int          rel_dly = 1;
  int          sc = 0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] tbl [4][4];

  logic [7:0] byte_q [$];
  logic [3:0] gnt_log [$];
  logic [3:0] done_log [$];
  int v_onehot, v_order, v_stable, v_early;
  logic p_lreq, p_ack, pend;
  logic [3:0] p_gnt;
  logic [7:0] p_data;

  assign link_ack = slave_en ? ack_slv : ack_tb;

  link_arbiter u_dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .burst_data (burst_data),
    .gnt        (gnt),
    .done       (done),
    .busy       (busy),
    .link_req   (link_req),
    .link_data  (link_data),
    .link_ack   (link_ack)
  );

  always #5 clk = ~clk;

  // slave: ack ack_dly cycles after req, drop rel_dly after release
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      ack_slv = 1'b0;
      sc = 0;
    end else if (link_req && !ack_slv) begin
      if (sc >= ack_dly) begin ack_slv = 1'b1; sc = 0; end
      else sc++;
    end else if (!link_req && ack_slv) begin
      if (sc >= rel_dly) begin ack_slv = 1'b0; sc = 0; end
      else sc++;
    end else begin
      sc = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      p_lreq = 1'b0; p_ack = 1'b0; pend = 1'b0;
      p_gnt = '0; p_data = '0;
    end else begin
      if (link_req && !p_lreq) byte_q.push_back(link_data);
      if (link_req && p_lreq && link_data != p_data) v_stable++;
      if (!link_req && p_lreq && !p_ack) v_early++;
      if ($countones(gnt) > 1 || $countones(done) > 1) v_onehot++;
      if (gnt != 0 && p_gnt == 0) begin
        if (pend) v_order++;
        pend = 1'b1;
        gnt_log.push_back(gnt);
      end
      if (done != 0) begin
        if (gnt_log.size() == 0 || done != gnt_log[$]) v_order++;
        pend = 1'b0;
        done_log.push_back(done);
      end
      p_lreq = link_req; p_ack = link_ack;
      p_gnt = gnt; p_data = link_data;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic clr_logs();
    byte_q.delete(); gnt_log.delete(); done_log.delete();
    v_onehot = 0; v_order = 0; v_stable = 0; v_early = 0;
  endtask

  task automatic do_reset(input logic [3:0] r);
    rst = 1'b0;
    req = r;
    slave_en = 1'b1;
    repeat (3) @(posedge clk);
    clr_logs();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_dones(input int n, input int budget);
    int k = 0;
    while (done_log.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk("done_tmo", 64'(done_log.size() >= n), 64'd1);
  endtask

  task automatic chk_bytes(input int base, input int r);
    for (int k = 0; k < 4; k++)
      chk($sformatf("byte%0d_r%0d", base + k, r),
          64'(byte_q[base+k]), 64'(tbl[r][k]));
  endtask

  task automatic chk_viol();
    chk("onehot", 64'(v_onehot), 64'd0);
    chk("order", 64'(v_order), 64'd0);
    chk("stable", 64'(v_stable), 64'd0);
    chk("early_drop", 64'(v_early), 64'd0);
  endtask

  initial begin
    int ord2 [6] = '{0, 1, 2, 3, 0, 1};
    int ord3 [5] = '{0, 2, 0, 1, 2};
    int k;
    tbl[0] = '{8'hA5, 8'h3C, 8'hF0, 8'h0F};
    tbl[1] = '{8'h11, 8'h22, 8'h33, 8'h44};
    tbl[2] = '{8'h5A, 8'h6B, 8'h7C, 8'h8D};
    tbl[3] = '{8'hC3, 8'hD4, 8'hE5, 8'h96};
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        burst_data[(i*4+j)*8 +: 8] = tbl[i][j];
    clr_logs();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outs", {gnt, done, busy, link_req, link_data},
        64'd0);

    // 1: single requester, latency and byte order
    do_reset(4'b0000);
    ack_dly = 1; rel_dly = 1;
    req = 4'b0001;
    @(posedge clk); #1;
    chk("t1_gnt_lat", 64'(gnt), 64'h1);
    chk("t1_lreq_lat", 64'(link_req), 64'h1);
    chk("t1_b0_lat", 64'(link_data), 64'hA5);
    wait_dones(1, 200);
    req = 4'b0000;
    repeat (4) @(negedge clk);
    chk("t1_nbytes", 64'(byte_q.size()), 64'd4);
    chk_bytes(0, 0);
    chk("t1_ngnt", 64'(gnt_log.size()), 64'd1);
    chk("t1_gnt", 64'(gnt_log[0]), 64'h1);
    chk("t1_ndone", 64'(done_log.size()), 64'd1);
    chk("t1_done", 64'(done_log[0]), 64'h1);
    chk("t1_busy", 64'(busy), 64'd0);
    chk_viol();

    // 2: all requesting, rotation 0,1,2,3,0,1
    do_reset(4'b1111);
    wait_dones(6, 600);
    req = 4'b0000;
    repeat (60) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t2_gnt%0d", i), 64'(gnt_log[i]),
          64'(4'b0001 << ord2[i]));
      chk_bytes(i*4, ord2[i]);
    end
    chk("t2_busy", 64'(busy), 64'd0);
    chk_viol();

    // 3: req 0,2 then req 1 raised during 2's burst
    do_reset(4'b0101);
    k = 0;
    while (gnt != 4'b0100 && k < 300) begin
      @(negedge clk); k++;
    end
    chk("t3_g2_tmo", 64'(gnt == 4'b0100), 64'd1);
    req[1] = 1'b1;
    wait_dones(5, 600);
    req = 4'b0000;
    repeat (60) @(negedge clk);
    for (int i = 0; i < 5; i++)
      chk($sformatf("t3_gnt%0d", i), 64'(gnt_log[i]),
          64'(4'b0001 << ord3[i]));
    chk_viol();

    // 4: slow slave
    do_reset(4'b0000);
    ack_dly = 5; rel_dly = 3;
    req = 4'b0001;
    wait_dones(1, 600);
    req = 4'b0000;
    repeat (20) @(negedge clk);
    chk("t4_nbytes", 64'(byte_q.size()), 64'd4);
    chk_bytes(0, 0);
    chk("t4_ndone", 64'(done_log.size()), 64'd1);
    chk_viol();
    ack_dly = 1; rel_dly = 1;

    // 5: reset mid-burst, then stale ack blocks grant
    do_reset(4'b0000);
    req = 4'b0001;
    k = 0;
    while (byte_q.size() < 3 && k < 200) begin
      @(negedge clk); k++;
    end
    chk("t5_b2_tmo", 64'(byte_q.size()), 64'd3);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("t5_async_gnt", 64'(gnt), 64'd0);
    chk("t5_async_busy", 64'(busy), 64'd0);
    chk("t5_async_lreq", 64'(link_req), 64'd0);
    chk("t5_async_data", 64'(link_data), 64'd0);
    chk("t5_async_done", 64'(done), 64'd0);
    chk("t5_no_done", 64'(done_log.size()), 64'd0);
    req = 4'b0010;
    ack_tb = 1'b1;
    slave_en = 1'b0;
    repeat (2) @(posedge clk);
    clr_logs();
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("t5_stale_gnt", 64'(gnt), 64'd0);
    chk("t5_stale_log", 64'(gnt_log.size()), 64'd0);
    ack_tb = 1'b0;
    slave_en = 1'b1;
    k = 0;
    while (gnt == 0 && k < 50) begin
      @(negedge clk); k++;
    end
    chk("t5_gnt", 64'(gnt), 64'h2);
    wait_dones(1, 200);
    req = 4'b0000;
    repeat (4) @(negedge clk);
    chk("t5_done", 64'(done_log[0]), 64'h2);
    chk_bytes(0, 1);
    chk_viol();

    // 6: requester 3 withdraws after first byte
    do_reset(4'b1000);
    k = 0;
    while (!(byte_q.size() >= 1 && !link_req && link_ack == 0)
           && k < 200) begin
      @(negedge clk); k++;
    end
    req = 4'b0000;
    wait_dones(1, 200);
    repeat (10) @(negedge clk);
    chk("t6_nbytes", 64'(byte_q.size()), 64'd4);
    chk_bytes(0, 3);
    chk("t6_ndone", 64'(done_log.size()), 64'd1);
    chk("t6_done", 64'(done_log[0]), 64'h8);
    chk("t6_ngnt", 64'(gnt_log.size()), 64'd1);
    chk("t6_idle", 64'({busy, gnt, link_req}), 64'd0);
    chk_viol();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
